// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO read-side UART transmitter.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic PAR_EVEN    = 1'b0;
    localparam logic PAR_ODD     = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity of one data word; PAR_TYP selects even (0) or odd (1).
module uart_tx_parity_calc
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/fifo_rd_uart_tx.sv
// Pops words from the async FIFO read port and sends each as a UART frame,
// one bit per R_CLK. Parity support is compiled in with UART_TX_PARITY_EN.
module fifo_rd_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  R_CLK,
    input  logic                  R_RST,
    input  logic                  EMPTY,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  R_INC,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    tx_state_e             state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
    logic                  tx_nxt, busy_nxt, rinc_nxt;
    logic                  load;

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic par_bit_q;
    logic par_bit_calc;

    uart_tx_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .data   (RD_DATA),
        .par_typ(PAR_TYP),
        .par_bit(par_bit_calc)
    );

    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            par_en_q <= 1'b0;
        end else if (load) begin
            par_en_q <= PAR_EN;
        end
    end

    always_ff @(posedge R_CLK) begin
        if (load) begin
            par_bit_q <= par_bit_calc;
        end
    end
`else
    logic unused_par;
    assign unused_par = PAR_EN ^ PAR_TYP;
`endif

    // Outputs are registered from next-state values so they line up with the state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        tx_nxt    = IDLE_LEVEL;
        busy_nxt  = 1'b1;
        rinc_nxt  = 1'b0;
        load      = 1'b0;

        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                load     = !EMPTY;
            end
            START: begin
                state_nxt = DATA;
                cnt_nxt   = '0;
                tx_nxt    = shreg[0];
                shreg_nxt = shreg >> 1;
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = STOP;
`ifdef UART_TX_PARITY_EN
                    if (par_en_q) begin
                        state_nxt = PARITY;
                        tx_nxt    = par_bit_q;
                    end
`endif
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                    tx_nxt    = shreg[0];
                    shreg_nxt = shreg >> 1;
                end
            end
            PARITY: begin
                state_nxt = STOP;
            end
            STOP: begin
                if (!EMPTY) begin
                    load = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase

        // Loading from IDLE or STOP both go straight to the start bit.
        if (load) begin
            state_nxt = START;
            cnt_nxt   = '0;
            shreg_nxt = RD_DATA;
            tx_nxt    = START_LEVEL;
            busy_nxt  = 1'b1;
            rinc_nxt  = 1'b1;
        end
    end

    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            state  <= IDLE;
            cnt    <= '0;
            TX_OUT <= IDLE_LEVEL;
            BUSY   <= 1'b0;
            R_INC  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            TX_OUT <= tx_nxt;
            BUSY   <= busy_nxt;
            R_INC  <= rinc_nxt;
        end
    end

    always_ff @(posedge R_CLK) begin
        shreg <= shreg_nxt;
    end

endmodule

// File: tb/tb_fifo_rd_uart_tx.sv
// Bench for fifo_rd_uart_tx: queue-based FIFO and frame-level UART model.
module tb_fifo_rd_uart_tx;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic          R_CLK = 1'b0;
    logic          R_RST;
    logic          EMPTY;
    logic [DW-1:0] RD_DATA;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          R_INC;
    logic          TX_OUT;
    logic          BUSY;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            pops     = 0;
    logic [DW-1:0] fifo[$];
    logic [2:0]    exp_q[$];

    fifo_rd_uart_tx #(
        .DATA_WIDTH(DW)
    ) dut (
        .R_CLK  (R_CLK),
        .R_RST  (R_RST),
        .EMPTY  (EMPTY),
        .RD_DATA(RD_DATA),
        .PAR_EN (PAR_EN),
        .PAR_TYP(PAR_TYP),
        .R_INC  (R_INC),
        .TX_OUT (TX_OUT),
        .BUSY   (BUSY)
    );

    always #5 R_CLK = ~R_CLK;

    function automatic void refresh();
        EMPTY = (fifo.size() == 0);
        if (fifo.size() == 0) RD_DATA = DW'($urandom);
        else                  RD_DATA = fifo[0];
    endfunction

    // One clock: FIFO pops during the R_INC cycle, outputs sampled at the falling edge.
    task automatic step(output logic [2:0] obs);
        @(posedge R_CLK);
        #2;
        if (R_INC === 1'b1) begin
            pops++;
            if (fifo.size() != 0) fifo.delete(0);
        end
        refresh();
        @(negedge R_CLK);
        obs = {TX_OUT, BUSY, R_INC};
    endtask

    // Expected {TX_OUT, BUSY, R_INC} per cycle for one frame.
    function automatic void model_frame(input logic [DW-1:0] w, input logic pen, input logic ptyp);
        exp_q.push_back(3'b011);
        for (int i = 0; i < DW; i++) exp_q.push_back({w[i], 2'b10});
        if (PAR_BUILT && pen) exp_q.push_back({(^w) ^ ptyp, 2'b10});
        exp_q.push_back(3'b110);
    endfunction

    function automatic void model_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(3'b100);
    endfunction

    task automatic run_expect(input string name, input bit scramble);
        logic [2:0] obs;
        logic [2:0] e;
        int         cyc;
        cyc = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            step(obs);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s cycle %0d: {tx,busy,r_inc} got %b expected %b", name, cyc, obs, e);
            end
            if (scramble && cyc == 1) {PAR_EN, PAR_TYP} = 2'($urandom);
            cyc++;
        end
    endtask

    task automatic check_pops(input string name, input int want);
        n_checks++;
        if (pops !== want || fifo.size() != 0) begin
            n_fail++;
            $display("FAIL %s: pops %0d left %0d, expected pops %0d left 0", name, pops, fifo.size(), want);
        end
    endtask

    task automatic test_reset();
        R_RST = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        fifo.delete();
        refresh();
        repeat (3) @(negedge R_CLK);
        n_checks++;
        if ({TX_OUT, BUSY, R_INC} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected 100", {TX_OUT, BUSY, R_INC});
        end
        R_RST = 1'b1;
    endtask

    task automatic test_single();
        pops = 0; PAR_EN = 1'b0; PAR_TYP = 1'($urandom);
        fifo.push_back(8'hA5);
        refresh();
        model_frame(8'hA5, 1'b0, PAR_TYP);
        model_idle(4);
        run_expect("single_a5", 1'b0);
        check_pops("single_a5_pops", 1);
    endtask

    task automatic test_parity();
        logic [DW-1:0] w;
        logic          pen, pt;
        for (int k = 0; k < 6; k++) begin
            pops = 0;
            w   = (k < 2) ? 8'hA5 : DW'($urandom);
            pen = (k < 2) ? 1'b1 : 1'($urandom);
            pt  = (k < 2) ? k[0] : 1'($urandom);
            PAR_EN = pen; PAR_TYP = pt;
            fifo.push_back(w);
            refresh();
            model_frame(w, pen, pt);
            model_idle(2);
            run_expect("parity_frame", 1'b1);
            check_pops("parity_pops", 1);
        end
        PAR_EN = 1'b0; PAR_TYP = 1'b0;
    endtask

    task automatic test_empty_idle();
        pops = 0;
        refresh();
        model_idle(20);
        run_expect("empty_idle", 1'b0);
        check_pops("empty_idle_pops", 0);
    endtask

    task automatic test_back_to_back();
        pops = 0; PAR_EN = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            fifo.push_back(DW'(i));
            model_frame(DW'(i), 1'b0, 1'b0);
        end
        refresh();
        model_idle(3);
        run_expect("back_to_back", 1'b0);
        check_pops("back_to_back_pops", 3);
    endtask

    task automatic test_reset_mid_frame();
        logic [DW-1:0] w0, w1;
        logic [2:0]    obs;
        logic [2:0]    e;
        pops = 0; PAR_EN = 1'b0;
        w0 = DW'($urandom); w1 = DW'($urandom);
        fifo.push_back(w0); fifo.push_back(w1);
        refresh();
        model_frame(w0, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            e = exp_q.pop_front();
            step(obs);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_mid_pre cycle %0d: got %b expected %b", c, obs, e);
            end
        end
        exp_q.delete();
        R_RST = 1'b0;
        #1;
        n_checks++;
        if ({TX_OUT, BUSY, R_INC} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_mid_immediate: got %b expected 100", {TX_OUT, BUSY, R_INC});
        end
        repeat (2) begin
            step(obs);
            n_checks++;
            if (obs !== 3'b100) begin
                n_fail++;
                $display("FAIL reset_mid_hold: got %b expected 100", obs);
            end
        end
        R_RST = 1'b1;
        model_frame(w1, 1'b0, 1'b0);
        model_idle(3);
        run_expect("reset_mid_post", 1'b0);
        check_pops("reset_mid_pops", 2);
    endtask

    task automatic test_read_until_empty();
        logic [DW-1:0] w;
        pops = 0;
        PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            w = DW'($urandom);
            fifo.push_back(w);
            model_frame(w, PAR_EN, PAR_TYP);
        end
        refresh();
        model_idle(4);
        run_expect("read_until_empty", 1'b0);
        check_pops("read_until_empty_pops", 8);
        n_checks++;
        if (EMPTY !== 1'b1 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL read_until_empty_final: empty %b busy %b expected 1 0", EMPTY, BUSY);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_empty_idle();
        test_back_to_back();
        test_reset_mid_frame();
        test_read_until_empty();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
